// File: rtl/peripheral_timer.sv
// Programmable prescaled 16-bit down-counting timer on the J1 I/O bus.
// Optional capture input enabled by defining TIMER_CAPTURE_EN.
module peripheral_timer #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
`ifdef TIMER_CAPTURE_EN
    input  logic        cap_in,
`endif
    output logic [15:0] d_out,
    output logic        irq
);

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_PRESCALE = 4'h2;
    localparam logic [3:0] ADDR_RELOAD   = 4'h4;
    localparam logic [3:0] ADDR_COUNT    = 4'h6;
    localparam logic [3:0] ADDR_STATUS   = 4'h8;
    localparam logic [3:0] ADDR_CAPTURE  = 4'hA;

    logic             en_r;
    logic             auto_r;
    logic             irq_en_r;
    logic [PRE_W-1:0] prescale_r;
    logic [PRE_W-1:0] pcnt_r;
    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] count_r;
    logic             expired_r;
    logic [CNT_W-1:0] capture_s;
    logic             captured_s;

    logic wr_ctrl_s;
    logic wr_prescale_s;
    logic wr_reload_s;
    logic wr_count_s;
    logic wr_status_s;
    logic tick_s;
    logic expire_s;
    logic [15:0] rd_data_s;
    logic [15:0] count_ext_s;
    logic [15:0] reload_ext_s;
    logic [15:0] prescale_ext_s;
    logic [15:0] capture_ext_s;

    // Write strobe decode per register.
    always_comb begin
        wr_ctrl_s     = 1'b0;
        wr_prescale_s = 1'b0;
        wr_reload_s   = 1'b0;
        wr_count_s    = 1'b0;
        wr_status_s   = 1'b0;
        if (cs && wr) begin
            case (addr)
                ADDR_CTRL:     wr_ctrl_s     = 1'b1;
                ADDR_PRESCALE: wr_prescale_s = 1'b1;
                ADDR_RELOAD:   wr_reload_s   = 1'b1;
                ADDR_COUNT:    wr_count_s    = 1'b1;
                ADDR_STATUS:   wr_status_s   = 1'b1;
                default:       wr_ctrl_s     = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // A software COUNT load in the tick cycle suppresses the expiry.
    assign tick_s   = en_r && (pcnt_r == prescale_r);
    assign expire_s = tick_s && (count_r == CNT_W'(0)) && !wr_count_s;

    // Control register; a CTRL write beats the one-shot auto-clear of EN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r     <= d_in[0];
            auto_r   <= d_in[1];
            irq_en_r <= d_in[2];
        end else if (expire_s && !auto_r) begin
            en_r     <= 1'b0;
        end
    end

    // Prescale and reload configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_r <= PRE_W'(0);
            reload_r   <= CNT_W'(0);
        end else begin
            if (wr_prescale_s) begin
                prescale_r <= d_in[PRE_W-1:0];
            end
            if (wr_reload_s) begin
                reload_r <= d_in[CNT_W-1:0];
            end
        end
    end

    // Prescaler: restarts when EN goes 0->1, wraps naturally if PRESCALE drops below it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r <= PRE_W'(0);
        end else if (wr_ctrl_s && d_in[0] && !en_r) begin
            pcnt_r <= PRE_W'(0);
        end else if (tick_s) begin
            pcnt_r <= PRE_W'(0);
        end else if (en_r) begin
            pcnt_r <= pcnt_r + PRE_W'(1);
        end
    end

    // Main counter: load, decrement on tick, reload on periodic expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_W'(0);
        end else if (wr_count_s) begin
            count_r <= d_in[CNT_W-1:0];
        end else if (tick_s) begin
            if (count_r != CNT_W'(0)) begin
                count_r <= count_r - CNT_W'(1);
            end else if (auto_r) begin
                count_r <= reload_r;
            end
        end
    end

    // Sticky expiry flag; a set in the same cycle as w1c wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expired_r <= 1'b0;
        end else if (expire_s) begin
            expired_r <= 1'b1;
        end else if (wr_status_s && d_in[0]) begin
            expired_r <= 1'b0;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic             cap_meta_r;
    logic             cap_sync_r;
    logic             cap_prev_r;
    logic             cap_edge_s;
    logic [CNT_W-1:0] capture_r;
    logic             captured_r;

    assign cap_edge_s = cap_sync_r && !cap_prev_r;

    // Two-flop synchroniser plus edge-detect stage for cap_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_meta_r <= 1'b0;
            cap_sync_r <= 1'b0;
            cap_prev_r <= 1'b0;
        end else begin
            cap_meta_r <= cap_in;
            cap_sync_r <= cap_meta_r;
            cap_prev_r <= cap_sync_r;
        end
    end

    // Capture register and sticky CAPTURED flag; set beats w1c.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capture_r  <= CNT_W'(0);
            captured_r <= 1'b0;
        end else if (cap_edge_s) begin
            capture_r  <= count_r;
            captured_r <= 1'b1;
        end else if (wr_status_s && d_in[1]) begin
            captured_r <= 1'b0;
        end
    end

    assign capture_s  = capture_r;
    assign captured_s = captured_r;
`else
    assign capture_s  = CNT_W'(0);
    assign captured_s = 1'b0;
`endif

    // Zero-extend narrow registers and mux read data while cs&rd.
    always_comb begin
        count_ext_s                 = 16'h0000;
        count_ext_s[CNT_W-1:0]      = count_r;
        reload_ext_s                = 16'h0000;
        reload_ext_s[CNT_W-1:0]     = reload_r;
        prescale_ext_s              = 16'h0000;
        prescale_ext_s[PRE_W-1:0]   = prescale_r;
        capture_ext_s               = 16'h0000;
        capture_ext_s[CNT_W-1:0]    = capture_s;
        rd_data_s                   = 16'h0000;
        if (cs && rd) begin
            case (addr)
                ADDR_CTRL:     rd_data_s = {13'h0000, irq_en_r, auto_r, en_r};
                ADDR_PRESCALE: rd_data_s = prescale_ext_s;
                ADDR_RELOAD:   rd_data_s = reload_ext_s;
                ADDR_COUNT:    rd_data_s = count_ext_s;
                ADDR_STATUS:   rd_data_s = {14'h0000, captured_s, expired_r};
                ADDR_CAPTURE:  rd_data_s = capture_ext_s;
                default:       rd_data_s = 16'h0000;
            endcase
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    assign d_out = rd_data_s;
    assign irq   = expired_r && irq_en_r;

endmodule
